// File: rtl/ysyx_25010008_axi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25010008_axi_sram_pkg
// Brief    : Shared FSM encodings, response codes, LFSR constants and the
//            address-window helper for the AXI-Lite SRAM.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25010008_axi_sram_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } rstate_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_HALF = 2'd1,
      W_WAIT = 2'd2,
      W_RESP = 2'd3
   } wstate_t;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5
   localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
   localparam logic [15:0] c_LFSR_TAPS = 16'h002D;

   // Offset is compared unsigned, so addresses below the base wrap out of range
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned depth_log2);
      logic [31:0] off;
      off = addr - base;
      return ({1'b0, off} < (33'd4 << depth_log2));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25010008_axi_sram_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25010008_axi_sram_if
// Brief    : AXI-Lite style five-channel bus bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25010008_axi_sram_if;

   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

endinterface
`default_nettype wire

// File: rtl/ysyx_25010008_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25010008_lfsr
// Brief    : 16-bit Fibonacci LFSR free-running every cycle; only built when
//            YSYX_25010008_SRAM_DELAY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef YSYX_25010008_SRAM_DELAY_EN
module ysyx_25010008_lfsr
   import ysyx_25010008_axi_sram_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   output logic [15:0] o_value
);

   logic [15:0] r_state;
   logic        w_feedback;

   assign w_feedback = ^(r_state & c_LFSR_TAPS);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= c_LFSR_SEED;
      end else begin
         r_state <= {w_feedback, r_state[15:1]};
      end
   end

   assign o_value = r_state;

endmodule
`endif
`default_nettype wire

// File: rtl/ysyx_25010008_axi_sram.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25010008_axi_sram
// Brief    : AXI-Lite SRAM slave with independent read/write FSMs and byte
//            strobes. Define YSYX_25010008_SRAM_DELAY_EN for random latency.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25010008_axi_sram
   import ysyx_25010008_axi_sram_pkg::*;
#(
   parameter logic [31:0] BASE       = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 12
)
(
   input  logic                        clock,
   input  logic                        reset,
   ysyx_25010008_axi_sram_if.slave     bus
);

   localparam int c_WORDS = 2 ** DEPTH_LOG2;

   logic [31:0]           r_mem [c_WORDS];

   rstate_t               r_rstate;
   logic [31:0]           r_araddr;
   logic [3:0]            r_rcnt;
   logic                  r_arready;
   logic                  r_rvalid;
   logic [31:0]           r_rdata;
   logic [1:0]            r_rresp;

   wstate_t               r_wstate;
   logic [31:0]           r_awaddr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic [3:0]            r_wcnt;
   logic                  r_awready;
   logic                  r_wready;
   logic                  r_bvalid;
   logic [1:0]            r_bresp;

   logic [3:0]            w_delay;
   logic                  w_rd_ok;
   logic                  w_wr_ok;
   logic                  w_aw_hs;
   logic                  w_w_hs;
   logic                  w_commit;
   logic [DEPTH_LOG2-1:0] w_ridx;
   logic [DEPTH_LOG2-1:0] w_widx;

`ifdef YSYX_25010008_SRAM_DELAY_EN
   logic [15:0] w_lfsr;

   ysyx_25010008_lfsr u_lfsr (
      .clock   (clock),
      .reset   (reset),
      .o_value (w_lfsr)
   );

   assign w_delay = w_lfsr[3:0];
`else
   assign w_delay = 4'd0;
`endif

   assign w_rd_ok  = addr_in_range(r_araddr, BASE, DEPTH_LOG2);
   assign w_wr_ok  = addr_in_range(r_awaddr, BASE, DEPTH_LOG2);
   assign w_ridx   = r_araddr[DEPTH_LOG2+1:2];
   assign w_widx   = r_awaddr[DEPTH_LOG2+1:2];
   assign w_aw_hs  = bus.awvalid && r_awready;
   assign w_w_hs   = bus.wvalid && r_wready;
   // Gated by reset so a write abandoned in W_WAIT never reaches the array
   assign w_commit = reset && (r_wstate == W_WAIT) && (r_wcnt == 4'd0) && w_wr_ok;

   always_ff @(posedge clock) begin
      if (w_commit) begin
         for (int i = 0; i < 4; i++) begin
            if (r_wstrb[i]) begin
               r_mem[w_widx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rstate  <= R_IDLE;
         r_araddr  <= 32'd0;
         r_rcnt    <= 4'd0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'd0;
         r_rresp   <= RESP_OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (bus.arvalid && r_arready) begin
                  r_araddr  <= bus.araddr;
                  r_rcnt    <= w_delay;
                  r_arready <= 1'b0;
                  r_rstate  <= R_WAIT;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            R_WAIT: begin
               if (r_rcnt == 4'd0) begin
                  r_rdata  <= w_rd_ok ? r_mem[w_ridx] : 32'd0;
                  r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_DECERR;
                  r_rvalid <= 1'b1;
                  r_rstate <= R_RESP;
               end else begin
                  r_rcnt <= r_rcnt - 4'd1;
               end
            end
            R_RESP: begin
               if (bus.rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_rstate  <= R_IDLE;
               end
            end
            default: begin
               r_rstate <= R_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wstate  <= W_IDLE;
         r_awaddr  <= 32'd0;
         r_wdata   <= 32'd0;
         r_wstrb   <= 4'd0;
         r_wcnt    <= 4'd0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         // Readies are only high in W_IDLE/W_HALF, so captures cannot fire elsewhere
         if (w_aw_hs) begin
            r_awaddr  <= bus.awaddr;
            r_awready <= 1'b0;
         end
         if (w_w_hs) begin
            r_wdata  <= bus.wdata;
            r_wstrb  <= bus.wstrb;
            r_wready <= 1'b0;
         end
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_hs && w_w_hs) begin
                  r_wcnt   <= w_delay;
                  r_wstate <= W_WAIT;
               end else if (w_aw_hs || w_w_hs) begin
                  r_wstate <= W_HALF;
               end else begin
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
               end
            end
            W_HALF: begin
               if (w_aw_hs || w_w_hs) begin
                  r_wcnt   <= w_delay;
                  r_wstate <= W_WAIT;
               end
            end
            W_WAIT: begin
               if (r_wcnt == 4'd0) begin
                  r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_DECERR;
                  r_bvalid <= 1'b1;
                  r_wstate <= W_RESP;
               end else begin
                  r_wcnt <= r_wcnt - 4'd1;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_wready  <= 1'b1;
                  r_wstate  <= W_IDLE;
               end
            end
            default: begin
               r_wstate <= W_IDLE;
            end
         endcase
      end
   end

   assign bus.arready = r_arready;
   assign bus.rvalid  = r_rvalid;
   assign bus.rdata   = r_rdata;
   assign bus.rresp   = r_rresp;
   assign bus.awready = r_awready;
   assign bus.wready  = r_wready;
   assign bus.bvalid  = r_bvalid;
   assign bus.bresp   = r_bresp;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25010008_axi_sram.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25010008_axi_sram
// Brief    : Directed self-checking bench for the AXI-Lite SRAM slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25010008_axi_sram;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   ysyx_25010008_axi_sram_if bus ();

   ysyx_25010008_axi_sram #(
      .BASE       (32'h8000_0000),
      .DEPTH_LOG2 (12)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_lat(input string tag, input int lat);
`ifdef YSYX_25010008_SRAM_DELAY_EN
      chk(tag, 32'(lat >= 1 && lat <= 16), 32'd1);
`else
      chk(tag, 32'(lat), 32'd1);
`endif
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_arready"}, 32'(bus.arready), 32'd0);
      chk({tag, "_awready"}, 32'(bus.awready), 32'd0);
      chk({tag, "_wready"},  32'(bus.wready),  32'd0);
      chk({tag, "_rvalid"},  32'(bus.rvalid),  32'd0);
      chk({tag, "_bvalid"},  32'(bus.bvalid),  32'd0);
      chk({tag, "_rdata"},   bus.rdata,        32'd0);
      chk({tag, "_rresp"},   32'(bus.rresp),   32'd0);
      chk({tag, "_bresp"},   32'(bus.bresp),   32'd0);
   endtask

   task automatic read_txn(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
      int n;
      @(negedge clock);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 40) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      bus.arvalid = 1'b0;
      lat = 0;
      while (!bus.rvalid && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      data = bus.rdata;
      resp = bus.rresp;
      bus.rready = 1'b1;
      @(negedge clock);
      bus.rready = 1'b0;
   endtask

   task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int lat);
      int n;
      @(negedge clock);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.wstrb   = s;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      n = 0;
      while (!(bus.awready && bus.wready) && n < 40) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      lat = 0;
      while (!bus.bvalid && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      resp = bus.bresp;
      bus.bready = 1'b1;
      @(negedge clock);
      bus.bready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [1:0]  rsp;
      int          lat;
      int          n;
      int          pulses;

      bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata  = '0;
      bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;

      // Reset held low: everything quiet
      repeat (3) @(negedge clock);
      chk_reset_outputs("rst");
      reset = 1'b1;
      @(negedge clock);
      chk("rel_arready", 32'(bus.arready), 32'd1);
      chk("rel_awready", 32'(bus.awready), 32'd1);
      chk("rel_wready",  32'(bus.wready),  32'd1);

      // Full-word write and read-back
      write_txn(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, rsp, lat);
      chk("w1_bresp", 32'(rsp), 32'd0);
      chk_lat("w1_lat", lat);
      read_txn(32'h8000_0010, d, rsp, lat);
      chk("r1_rdata", d, 32'hDEAD_BEEF);
      chk("r1_rresp", 32'(rsp), 32'd0);
      chk_lat("r1_lat", lat);

      // Single byte lane 2
      write_txn(32'h8000_0010, 32'h00AB_0000, 4'b0100, rsp, lat);
      chk("w2_bresp", 32'(rsp), 32'd0);
      read_txn(32'h8000_0010, d, rsp, lat);
      chk("r2_rdata", d, 32'hDEAB_BEEF);
      read_txn(32'h8000_0013, d, rsp, lat);
      chk("r2_unaligned", d, 32'hDEAB_BEEF);

      // W beat three cycles ahead of AW
      @(negedge clock);
      bus.wdata  = 32'h1234_5678;
      bus.wstrb  = 4'hF;
      bus.wvalid = 1'b1;
      @(negedge clock);
      bus.wvalid = 1'b0;
      chk("wfirst_wready",  32'(bus.wready),  32'd0);
      chk("wfirst_awready", 32'(bus.awready), 32'd1);
      chk("wfirst_bvalid",  32'(bus.bvalid),  32'd0);
      repeat (2) @(negedge clock);
      bus.awaddr  = 32'h8000_0020;
      bus.awvalid = 1'b1;
      bus.bready  = 1'b1;
      pulses = 0;
      rsp = 2'b01;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (i == 0) bus.awvalid = 1'b0;
         if (bus.bvalid) begin
            pulses++;
            rsp = bus.bresp;
         end
      end
      bus.bready = 1'b0;
      chk("wfirst_pulses", 32'(pulses), 32'd1);
      chk("wfirst_bresp",  32'(rsp),    32'd0);
      read_txn(32'h8000_0020, d, rsp, lat);
      chk("wfirst_rdata", d, 32'h1234_5678);

      // Out-of-range accesses on both sides of the window
      write_txn(32'h8000_0000, 32'hCAFE_F00D, 4'hF, rsp, lat);
      write_txn(32'h8000_3FFC, 32'h0BAD_C0DE, 4'hF, rsp, lat);
      chk("last_bresp", 32'(rsp), 32'd0);
      read_txn(32'h7FFF_FFFC, d, rsp, lat);
      chk("oor_lo_rresp", 32'(rsp), 32'd3);
      chk("oor_lo_rdata", d, 32'd0);
      read_txn(32'h8000_4000, d, rsp, lat);
      chk("oor_hi_rresp", 32'(rsp), 32'd3);
      chk("oor_hi_rdata", d, 32'd0);
      write_txn(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, rsp, lat);
      chk("oor_hi_bresp", 32'(rsp), 32'd3);
      write_txn(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, rsp, lat);
      chk("oor_lo_bresp", 32'(rsp), 32'd3);
      read_txn(32'h8000_0000, d, rsp, lat);
      chk("oor_alias0", d, 32'hCAFE_F00D);
      read_txn(32'h8000_3FFC, d, rsp, lat);
      chk("oor_aliasN", d, 32'h0BAD_C0DE);

      // Back-pressure on R while a write runs alongside
      @(negedge clock);
      bus.araddr  = 32'h8000_0010;
      bus.arvalid = 1'b1;
      @(negedge clock);
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("hold_rvalid_seen", 32'(bus.rvalid), 32'd1);
      bus.awaddr  = 32'h8000_0024;
      bus.wdata   = 32'h5A5A_5A5A;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      pulses = 0;
      rsp = 2'b01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (i == 0) begin
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
         end
         if (bus.bvalid) begin
            pulses++;
            rsp = bus.bresp;
         end
         chk("hold_rvalid", 32'(bus.rvalid), 32'd1);
         chk("hold_rdata",  bus.rdata,       32'hDEAB_BEEF);
      end
      n = 0;
      while (pulses == 0 && n < 40) begin
         @(negedge clock);
         if (bus.bvalid) begin
            pulses++;
            rsp = bus.bresp;
         end
         n++;
      end
      bus.bready = 1'b0;
      chk("hold_wr_pulses", 32'(pulses), 32'd1);
      chk("hold_wr_bresp",  32'(rsp),    32'd0);
      chk("hold_rdata_end", bus.rdata,   32'hDEAB_BEEF);
      bus.rready = 1'b1;
      @(negedge clock);
      bus.rready = 1'b0;
      chk("hold_rvalid_drop", 32'(bus.rvalid), 32'd0);
      read_txn(32'h8000_0024, d, rsp, lat);
      chk("hold_wr_rdata", d, 32'h5A5A_5A5A);

`ifndef YSYX_25010008_SRAM_DELAY_EN
      // Read sample and write commit to one word on the same edge
      @(negedge clock);
      bus.araddr  = 32'h8000_0010;
      bus.arvalid = 1'b1;
      bus.awaddr  = 32'h8000_0010;
      bus.wdata   = 32'h1111_1111;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      @(negedge clock);
      bus.arvalid = 1'b0;
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      @(negedge clock);
      chk("same_rvalid", 32'(bus.rvalid), 32'd1);
      chk("same_bvalid", 32'(bus.bvalid), 32'd1);
      chk("same_rdata",  bus.rdata,       32'hDEAB_BEEF);
      bus.rready = 1'b1;
      bus.bready = 1'b1;
      @(negedge clock);
      bus.rready = 1'b0;
      bus.bready = 1'b0;
      read_txn(32'h8000_0010, d, rsp, lat);
      chk("same_after", d, 32'h1111_1111);
`endif

      // Reset while the write sits in W_WAIT
      @(negedge clock);
      bus.awaddr  = 32'h8000_0024;
      bus.wdata   = 32'hFFFF_FFFF;
      bus.wstrb   = 4'hF;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      @(negedge clock);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      chk_reset_outputs("midrst");
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_rel_awready", 32'(bus.awready), 32'd1);
      read_txn(32'h8000_0024, d, rsp, lat);
      chk("midrst_nocommit", d, 32'h5A5A_5A5A);
      chk_lat("midrst_lat", lat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ysyx_25010008_axi_sram.md
YSYX_25010008_AXI_SRAM -- requirements
Module: ysyx_25010008_axi_sram

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, first byte address served.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, log2 of word count; array is 2**DEPTH_LOG2 x 32 bit.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have ports araddr in 32, arvalid in 1, arready out 1: read-address channel.
REQ-006 SHALL have ports rdata out 32, rresp out 2, rvalid out 1, rready in 1: read-data channel.
REQ-007 SHALL have ports awaddr in 32, awvalid in 1, awready out 1: write-address channel.
REQ-008 SHALL have ports wdata in 32, wstrb in 4, wvalid in 1, wready out 1: write-data channel.
REQ-009 SHALL have ports bresp out 2, bvalid out 1, bready in 1: write-response channel.

Function
REQ-010 Read and write paths SHALL be independent FSMs; both may be busy concurrently.
REQ-011 Read FSM states: R_IDLE (arready=1), R_WAIT, R_RESP (rvalid=1); no other states.
REQ-012 R_IDLE->R_WAIT on arvalid&&arready; araddr latched that cycle; arready=0 outside R_IDLE.
REQ-013 R_WAIT->R_RESP when delay counter reaches 0; rdata/rresp registered on entry, held stable while rvalid=1.
REQ-014 R_RESP->R_IDLE on rready; rvalid deasserts the following cycle; rvalid never drops without rready.
REQ-015 Write FSM states: W_IDLE (awready=wready=1), W_HALF, W_WAIT, W_RESP (bvalid=1).
REQ-016 AW and W accepted in either order or same cycle; each ready drops after its own handshake; W_HALF holds the first-received beat; both captured -> W_WAIT.
REQ-017 Write SHALL commit exactly once, on the W_WAIT->W_RESP transition, updating only byte lanes with wstrb[i]=1.
REQ-018 W_RESP->W_IDLE on bready; bvalid held until then.
REQ-019 Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored (alignment via wstrb is the master's duty).
REQ-020 Address in range iff (addr-BASE) < 4*2**DEPTH_LOG2, unsigned 32-bit compare (wrap below BASE = out of range).
REQ-021 In-range: rresp/bresp=2'b00. Out-of-range: 2'b11 (DECERR), rdata=0, no array write.
REQ-022 Read sampling and write commit to same word in same cycle: read returns pre-write data.
REQ-023 Without delay feature, latency fixed: handshake at cycle N -> rvalid/bvalid high at N+1 (R_WAIT/W_WAIT last one cycle).

Reset
REQ-024 While reset=0: both FSMs idle-pending; arready=awready=wready=0, rvalid=bvalid=0, rdata=0, rresp=bresp=0.
REQ-025 First cycle after release: FSMs enter R_IDLE/W_IDLE, readies high.
REQ-026 Reset mid-transaction SHALL abandon it; uncommitted writes dropped; array contents not cleared.

Configuration
REQ-027 Macro YSYX_25010008_SRAM_DELAY_EN defined: 16-bit LFSR (poly x^16+x^14+x^13+x^11+1, seed 16'hACE1, advances every cycle) loads counter with lfsr[3:0] on R_WAIT/W_WAIT entry; response at N+1+d, d in 0..15.
REQ-028 Macro undefined: no LFSR logic, behaviour per REQ-023.

Structure
REQ-029 Shared package SHALL hold FSM state encodings, RESP_OKAY=2'b00, RESP_DECERR=2'b11, LFSR seed/taps.
REQ-030 Sub-module ysyx_25010008_lfsr (16-bit Fibonacci LFSR) instantiated only under the macro.

Verification
REQ-031 Write 32'hDEADBEEF, wstrb 4'hF to 32'h8000_0010, then read -> bresp 00, rdata 32'hDEADBEEF, rresp 00.
REQ-032 wstrb 4'b0100, wdata 32'h00AB_0000 to same word -> read 32'hDEABBEEF.
REQ-033 W beat 3 cycles before AW, then AW -> single commit, exactly one bvalid pulse.
REQ-034 Read 32'h7FFF_FFFC and 32'h8000_4000 (DEPTH_LOG2=12) -> rresp 11, rdata 0; write there -> bresp 11, array unchanged.
REQ-035 Hold rready=0 for 5 cycles in R_RESP -> rvalid and rdata stable throughout; concurrent write completes meanwhile.
REQ-036 Reset asserted in W_WAIT -> no commit, all outputs per REQ-024; macro off: 1-cycle latency; macro on: latency within 1..16.
